// File: rtl/rf_scoreboard.sv
// Two-read/one-write register file with per-register pending-write counters.
// Decode reserves a destination, writeback releases it; busy flags expose hazards.
module rf_scoreboard #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 2,
  parameter int CNT_W    = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_busy_a,
  output logic              rd_busy_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_ok,
  output logic              pending_any
);

  localparam int NUM_REGS = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] MAX_PEND = '1;

  logic [DATA_W-1:0] mem [NUM_REGS];
  logic [CNT_W-1:0]  cnt [NUM_REGS];
  logic [NUM_REGS-1:0] rel_hit;
  logic [NUM_REGS-1:0] acc_hit;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a,
                                                  input logic [DATA_W-1:0] stored);
    logic [DATA_W-1:0] d;
    d = stored;
    if ((BYPASS != 0) && wr_en && (wr_addr == a)) d = wr_data;
    if (is_zero(a)) d = '0;
    return d;
  endfunction

  // The last outstanding write landing this cycle clears busy early when forwarding.
  function automatic logic busy_port(input logic [ADDR_W-1:0] a,
                                     input logic [CNT_W-1:0]  c);
    logic b;
    b = (c != '0);
    if ((BYPASS != 0) && wr_en && (wr_addr == a) && (c == CNT_W'(1))) b = 1'b0;
    if (is_zero(a)) b = 1'b0;
    return b;
  endfunction

  always_comb begin
    rd_data_a = read_port(rd_addr_a, mem[rd_addr_a]);
    rd_data_b = read_port(rd_addr_b, mem[rd_addr_b]);
    rd_busy_a = busy_port(rd_addr_a, cnt[rd_addr_a]);
    rd_busy_b = busy_port(rd_addr_b, cnt[rd_addr_b]);
  end

  // A full counter can still accept when a release lands on it in the same cycle.
  always_comb begin
    rsv_ok = 1'b0;
    if (reset_n && rsv_en) begin
      if (is_zero(rsv_addr))
        rsv_ok = 1'b1;
      else
        rsv_ok = (cnt[rsv_addr] < MAX_PEND) ||
                 (wr_en && (wr_addr == rsv_addr) && (cnt[rsv_addr] != '0));
    end
  end

  always_comb begin
    rel_hit = '0;
    acc_hit = '0;
    if (wr_en && !is_zero(wr_addr) && (cnt[wr_addr] != '0)) rel_hit[wr_addr] = 1'b1;
    if (rsv_ok && !is_zero(rsv_addr)) acc_hit[rsv_addr] = 1'b1;
  end

  always_comb begin
    pending_any = 1'b0;
    for (int i = 0; i < NUM_REGS; i++)
      if (cnt[i] != '0) pending_any = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
        cnt[i] <= '0;
      end
    end else begin
      if (wr_en && !is_zero(wr_addr)) mem[wr_addr] <= wr_data;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (rel_hit[i] && !acc_hit[i])
          cnt[i] <= cnt[i] - 1'b1;
        else if (acc_hit[i] && !rel_hit[i])
          cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rf_scoreboard.sv
// Bench for rf_scoreboard: three configurations share one stimulus stream and are
// checked each cycle against a spec-level model plus directed literal expectations.
module tb_rf_scoreboard;

  logic        clk;
  logic        reset_n;
  logic [1:0]  rd_addr_a, rd_addr_b, wr_addr, rsv_addr;
  logic        wr_en, rsv_en;
  logic [15:0] wr_data;

  logic [15:0] rda [3];
  logic [15:0] rdb [3];
  logic        bsa [3];
  logic        bsb [3];
  logic        ok  [3];
  logic        pnd [3];

  int n_checks = 0;
  int n_fail   = 0;

  // instance 0: bypass; instance 1: no bypass; instance 2: bypass + zero register
  rf_scoreboard #(.DATA_W(16), .ADDR_W(2), .CNT_W(2), .BYPASS(1), .ZERO_REG(0)) u_dut (
    .clk(clk), .reset_n(reset_n), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rda[0]), .rd_data_b(rdb[0]), .rd_busy_a(bsa[0]), .rd_busy_b(bsb[0]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .rsv_ok(ok[0]), .pending_any(pnd[0]));

  rf_scoreboard #(.DATA_W(16), .ADDR_W(2), .CNT_W(2), .BYPASS(0), .ZERO_REG(0)) u_nobyp (
    .clk(clk), .reset_n(reset_n), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rda[1]), .rd_data_b(rdb[1]), .rd_busy_a(bsa[1]), .rd_busy_b(bsb[1]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .rsv_ok(ok[1]), .pending_any(pnd[1]));

  rf_scoreboard #(.DATA_W(16), .ADDR_W(2), .CNT_W(2), .BYPASS(1), .ZERO_REG(1)) u_zero (
    .clk(clk), .reset_n(reset_n), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rda[2]), .rd_data_b(rdb[2]), .rd_busy_a(bsa[2]), .rd_busy_b(bsb[2]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .rsv_ok(ok[2]), .pending_any(pnd[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int MAXP = 3;
  int m_mem [3][4];
  int m_cnt [3][4];
  bit byp [3] = '{1'b1, 1'b0, 1'b1};
  bit zr  [3] = '{1'b0, 1'b0, 1'b1};
  bit model_valid = 1'b0;

  function automatic bit zaddr(int k, int a);
    return zr[k] && (a == 0);
  endfunction

  function automatic int exp_rd(int k, int a);
    if (zaddr(k, a)) return 0;
    if (byp[k] && wr_en && (int'(wr_addr) == a)) return int'(wr_data);
    return m_mem[k][a];
  endfunction

  function automatic int exp_busy(int k, int a);
    if (zaddr(k, a)) return 0;
    if (byp[k] && wr_en && (int'(wr_addr) == a) && (m_cnt[k][a] == 1)) return 0;
    return (m_cnt[k][a] != 0) ? 1 : 0;
  endfunction

  function automatic int exp_ok(int k);
    int a;
    a = int'(rsv_addr);
    if (!reset_n || !rsv_en) return 0;
    if (zaddr(k, a)) return 1;
    if (m_cnt[k][a] < MAXP) return 1;
    if (wr_en && (int'(wr_addr) == a) && (m_cnt[k][a] > 0)) return 1;
    return 0;
  endfunction

  function automatic int exp_pend(int k);
    int s;
    s = 0;
    for (int i = 0; i < 4; i++) s += m_cnt[k][i];
    return (s != 0) ? 1 : 0;
  endfunction

  always begin
    @(negedge clk);
    if (model_valid) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("m%0d rd_data_a", k), int'(rda[k]), exp_rd(k, int'(rd_addr_a)));
        chk($sformatf("m%0d rd_data_b", k), int'(rdb[k]), exp_rd(k, int'(rd_addr_b)));
        chk($sformatf("m%0d rd_busy_a", k), int'(bsa[k]), exp_busy(k, int'(rd_addr_a)));
        chk($sformatf("m%0d rd_busy_b", k), int'(bsb[k]), exp_busy(k, int'(rd_addr_b)));
        chk($sformatf("m%0d rsv_ok", k), int'(ok[k]), exp_ok(k));
        chk($sformatf("m%0d pending_any", k), int'(pnd[k]), exp_pend(k));
      end
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (!reset_n) begin
        for (int i = 0; i < 4; i++) begin
          m_mem[k][i] = 0;
          m_cnt[k][i] = 0;
        end
      end else begin
        int acc, wa, ra;
        acc = exp_ok(k);
        wa  = int'(wr_addr);
        ra  = int'(rsv_addr);
        if (wr_en && !zaddr(k, wa) && m_cnt[k][wa] > 0) m_cnt[k][wa] -= 1;
        if (acc != 0 && !zaddr(k, ra)) m_cnt[k][ra] += 1;
        if (wr_en && !zaddr(k, wa)) m_mem[k][wa] = int'(wr_data);
      end
    end
    if (!reset_n) model_valid = 1'b1;
  end

  // ---------------- directed stimulus ----------------
  task automatic idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0;
    rd_addr_a = '0; rd_addr_b = '0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    nxt();
    nxt();
    reset_n = 1'b1;

    @(negedge clk);
    chk("reset rd_data_a", int'(rda[0]), 0);
    chk("reset rd_busy_a", int'(bsa[0]), 0);
    chk("reset pending_any", int'(pnd[0]), 0);
    nxt();

    // basic write / read
    idle(); wr_en = 1'b1; wr_addr = 2'd2; wr_data = 16'h1234; nxt();
    idle(); wr_en = 1'b1; wr_addr = 2'd3; wr_data = 16'hBEEF; nxt();
    idle(); rd_addr_a = 2'd2; rd_addr_b = 2'd3;
    @(negedge clk);
    chk("t1 rd_data_a", int'(rda[0]), 16'h1234);
    chk("t1 rd_data_b", int'(rdb[0]), 16'hBEEF);
    chk("t1 rd_busy_a", int'(bsa[0]), 0);
    chk("t1 rd_busy_b", int'(bsb[0]), 0);
    chk("t1 pending_any", int'(pnd[0]), 0);
    nxt();

    // fill r1 to its limit, then one refused request
    idle(); rd_addr_a = 2'd1; rsv_en = 1'b1; rsv_addr = 2'd1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("t2 rsv_ok #%0d", i), int'(ok[0]), (i < 3) ? 1 : 0);
      if (i == 0) chk("t2 busy same-cycle rsv", int'(bsa[0]), 0);
      if (i == 3) chk("t2 busy full", int'(bsa[0]), 1);
      nxt();
    end
    idle(); rd_addr_a = 2'd1; rsv_en = 1'b1; rsv_addr = 2'd1;
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 16'h0A0A;
    @(negedge clk);
    chk("t2 rsv_ok with release", int'(ok[0]), 1);
    chk("t2 busy cnt3", int'(bsa[0]), 1);
    nxt();
    idle(); rd_addr_a = 2'd1; rsv_en = 1'b1; rsv_addr = 2'd1;
    @(negedge clk);
    chk("t2 still full rsv_ok", int'(ok[0]), 0);
    chk("t2 pending_any", int'(pnd[0]), 1);
    chk("t2 rd_data_a", int'(rda[0]), 16'h0A0A);
    nxt();

    // drain r1 to a count of one
    idle(); rd_addr_a = 2'd1; wr_en = 1'b1; wr_addr = 2'd1; wr_data = 16'h1111; nxt();
    wr_data = 16'h2222; nxt();

    // last pending write lands while being read
    wr_data = 16'h00FF;
    @(negedge clk);
    chk("t3 byp rd_data_a", int'(rda[0]), 16'h00FF);
    chk("t3 byp rd_busy_a", int'(bsa[0]), 0);
    chk("t3 nobyp rd_data_a", int'(rda[1]), 16'h2222);
    chk("t3 nobyp rd_busy_a", int'(bsa[1]), 1);
    nxt();
    idle(); rd_addr_a = 2'd1;
    @(negedge clk);
    chk("t3 after byp rd_data_a", int'(rda[0]), 16'h00FF);
    chk("t3 after nobyp rd_data_a", int'(rda[1]), 16'h00FF);
    chk("t3 after nobyp busy", int'(bsa[1]), 0);
    chk("t3 after pending_any", int'(pnd[0]), 0);
    nxt();

    // untracked write to r0
    idle(); wr_en = 1'b1; wr_addr = 2'd0; wr_data = 16'h5555; nxt();
    idle(); rd_addr_a = 2'd0;
    @(negedge clk);
    chk("t4 rd_data_a", int'(rda[0]), 16'h5555);
    chk("t4 pending_any", int'(pnd[0]), 0);
    chk("t4 zero rd_data_a", int'(rda[2]), 0);
    nxt();

    // zero register ignores writes and reservations
    idle(); rd_addr_a = 2'd0; wr_en = 1'b1; wr_addr = 2'd0; wr_data = 16'hFFFF;
    rsv_en = 1'b1; rsv_addr = 2'd0;
    @(negedge clk);
    chk("t5 zero rsv_ok", int'(ok[2]), 1);
    chk("t5 zero rd_data_a", int'(rda[2]), 0);
    chk("t5 zero rd_busy_a", int'(bsa[2]), 0);
    chk("t5 byp rd_data_a", int'(rda[0]), 16'hFFFF);
    nxt();
    idle(); rd_addr_a = 2'd0;
    @(negedge clk);
    chk("t5 zero pending_any", int'(pnd[2]), 0);
    chk("t5 zero rd_data_a next", int'(rda[2]), 0);
    chk("t5 plain pending_any", int'(pnd[0]), 1);
    chk("t5 plain rd_busy_a", int'(bsa[0]), 1);
    nxt();

    // reset wins over simultaneous write and reservation
    idle(); rsv_en = 1'b1; rsv_addr = 2'd2; nxt();
    idle(); rsv_en = 1'b1; rsv_addr = 2'd3; nxt();
    idle(); reset_n = 1'b0; wr_en = 1'b1; wr_addr = 2'd2; wr_data = 16'h7777;
    rsv_en = 1'b1; rsv_addr = 2'd3; rd_addr_a = 2'd2; rd_addr_b = 2'd3;
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk($sformatf("t6 rsv_ok in reset %0d", k), int'(ok[k]), 0);
    nxt();
    idle(); reset_n = 1'b1; rd_addr_a = 2'd2; rd_addr_b = 2'd3;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t6 rd_data_a %0d", k), int'(rda[k]), 0);
      chk($sformatf("t6 rd_data_b %0d", k), int'(rdb[k]), 0);
      chk($sformatf("t6 rd_busy_a %0d", k), int'(bsa[k]), 0);
      chk($sformatf("t6 pending_any %0d", k), int'(pnd[k]), 0);
    end
    nxt();

    // mixed traffic, checked by the model only
    for (int i = 0; i < 80; i++) begin
      wr_en     = 1'($urandom_range(0, 1));
      wr_addr   = 2'($urandom_range(0, 3));
      wr_data   = 16'($urandom);
      rsv_en    = 1'($urandom_range(0, 1));
      rsv_addr  = 2'($urandom_range(0, 3));
      rd_addr_a = 2'($urandom_range(0, 3));
      rd_addr_b = 2'($urandom_range(0, 3));
      nxt();
    end

    idle();
    nxt();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
